mrv1_thread_sched: RTL

//  Per-thread scheduler for the multithreaded core. Holds the active mask and per-thread PC.

---
 rtl/mrv1_pkg.sv | 15 +
 rtl/mrv1_rr_arb.sv | 29 ++
 rtl/mrv1_thread_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/mrv1_pkg.sv
// Shared definitions for the mrv1 core: thread-control command bundle and instruction size.
package mrv1_pkg;

    localparam int MRV_INSN_BYTES = 4;
    localparam int MRV_TID_W_MAX  = 8;
    localparam int MRV_PC_W_MAX   = 64;

    typedef struct packed {
        logic                     vld;
        logic [MRV_TID_W_MAX-1:0] tid;
        logic                     tspawn_vld;
        logic [MRV_PC_W_MAX-1:0]  tspawn_pc;
    } mrv_th_ctl_s;

endpackage

// File: rtl/mrv1_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, modulo N (N a power of two).
module mrv1_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mrv1_thread_sched.sv
// Per-thread scheduler: active mask, per-thread PC, spawn/stop/redirect handling and
// round-robin fetch selection among eligible threads.
module mrv1_thread_sched
    import mrv1_pkg::*;
#(
    parameter int                  NUM_THREADS_P = 4,
    parameter int                  PC_WIDTH_P    = 32,
    parameter logic [PC_WIDTH_P-1:0] RESET_PC_P  = '0,
    localparam int                 TID_WIDTH_LP  = $clog2(NUM_THREADS_P)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     th_ctl_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  th_ctl_tid_i,
    input  logic                     th_ctl_tspawn_vld_i,
    input  logic [PC_WIDTH_P-1:0]    th_ctl_tspawn_pc_i,
    output logic                     spawn_done_o,
    output logic                     spawn_fail_o,
    output logic [TID_WIDTH_LP-1:0]  spawn_tid_o,
    input  logic                     br_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  br_tid_i,
    input  logic [PC_WIDTH_P-1:0]    br_pc_i,
    input  logic [NUM_THREADS_P-1:0] th_stall_i,
    output logic                     fetch_vld_o,
    output logic [TID_WIDTH_LP-1:0]  fetch_tid_o,
    output logic [PC_WIDTH_P-1:0]    fetch_pc_o,
    input  logic                     fetch_rdy_i,
    output logic [NUM_THREADS_P-1:0] active_mask_o,
    output logic                     all_idle_o
);

    logic [NUM_THREADS_P-1:0] active;
    logic [PC_WIDTH_P-1:0]    pc [NUM_THREADS_P];
    logic [TID_WIDTH_LP-1:0]  rr_ptr;

    logic [NUM_THREADS_P-1:0] elig;
    logic                     fetch_fire;
    logic                     spawn_cmd;
    logic                     stop_cmd;
    logic                     free_vld;
    logic [TID_WIDTH_LP-1:0]  free_tid;

    assign elig       = active & ~th_stall_i;
    assign fetch_fire = fetch_vld_o & fetch_rdy_i;
    assign spawn_cmd  = th_ctl_vld_i & th_ctl_tspawn_vld_i;
    assign stop_cmd   = th_ctl_vld_i & ~th_ctl_tspawn_vld_i;

    mrv1_rr_arb #(
        .N (NUM_THREADS_P)
    ) u_fetch_arb (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt_vld (fetch_vld_o),
        .gnt_idx (fetch_tid_o)
    );

    assign fetch_pc_o    = fetch_vld_o ? pc[fetch_tid_o] : '0;
    assign active_mask_o = active;
    assign all_idle_o    = ~|active;

    // Lowest-index inactive thread, taken from the mask at the start of the cycle.
    always_comb begin
        free_vld = 1'b0;
        free_tid = '0;
        for (int t = NUM_THREADS_P - 1; t >= 0; t--) begin
            if (!active[t]) begin
                free_vld = 1'b1;
                free_tid = TID_WIDTH_LP'(t);
            end
        end
    end

    // Redirect is applied last so it overrides the fetch increment on the same thread.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active       <= NUM_THREADS_P'(1);
            rr_ptr       <= '0;
            spawn_done_o <= 1'b0;
            spawn_fail_o <= 1'b0;
            spawn_tid_o  <= '0;
            for (int t = 0; t < NUM_THREADS_P; t++) begin
                pc[t] <= (t == 0) ? RESET_PC_P : '0;
            end
        end else begin
            spawn_done_o <= 1'b0;
            spawn_fail_o <= 1'b0;
            if (fetch_fire) begin
                pc[fetch_tid_o] <= pc[fetch_tid_o] + PC_WIDTH_P'(MRV_INSN_BYTES);
                rr_ptr          <= fetch_tid_o + TID_WIDTH_LP'(1);
            end
            if (spawn_cmd) begin
                if (free_vld) begin
                    active[free_tid] <= 1'b1;
                    pc[free_tid]     <= th_ctl_tspawn_pc_i;
                    spawn_done_o     <= 1'b1;
                    spawn_tid_o      <= free_tid;
                end else begin
                    spawn_fail_o <= 1'b1;
                end
            end else if (stop_cmd) begin
                active[th_ctl_tid_i] <= 1'b0;
            end
            if (br_vld_i) begin
                pc[br_tid_i] <= br_pc_i;
            end
        end
    end

endmodule
